// File: rtl/flappy_pkg.sv
// Shared geometry, colours and shadow-register layout for the flappy pixel path.
package flappy_pkg;

  // Visible screen limits
  localparam int unsigned ScreenW = 640;
  localparam int unsigned ScreenH = 480;

  // Geometry defaults
  localparam int unsigned DefBirdX      = 160;
  localparam int unsigned DefBirdW      = 17;
  localparam int unsigned DefBirdH      = 12;
  localparam int unsigned DefPipeW      = 52;
  localparam int unsigned DefGapH       = 100;
  localparam int unsigned DefGroundY    = 400;
  localparam int unsigned DefFlapFrames = 8;

  // Colours, bbbb_gggg_rrrr
  localparam logic [11:0] ColBlank  = 12'h000;
  localparam logic [11:0] ColBird   = 12'h0FF;
  localparam logic [11:0] ColWing   = 12'h0AF;
  localparam logic [11:0] ColPipe   = 12'h0C2;
  localparam logic [11:0] ColGround = 12'h3AD;
  localparam logic [11:0] ColSky    = 12'hEC4;

  // Game-object positions, as latched once per frame
  typedef struct packed {
    logic [8:0] bird_y;
    logic [9:0] pipe0_x;
    logic [8:0] pipe0_gap;
    logic [9:0] pipe1_x;
    logic [8:0] pipe1_gap;
  } obj_pos_t;

  localparam obj_pos_t ObjPosReset = '{
    bird_y:    9'd240,
    pipe0_x:   10'd1023,
    pipe0_gap: 9'd0,
    pipe1_x:   10'd1023,
    pipe1_gap: 9'd0
  };

  // v in [lo, lo+len); 11-bit sum so right/bottom edges never wrap
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/flappy_pixel_gen_if.sv
// Pixel-read bus between the VGA sync generator (master) and a pixel source (slave).
interface flappy_pixel_gen_if;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic [11:0] d_in;

  modport master (output row_addr, output col_addr, output rdn, input d_in);
  modport slave  (input row_addr, input col_addr, input rdn, output d_in);
endinterface

// File: rtl/flappy_frame_sync.sv
// Frame-end detection, per-frame tick, position shadow registers and wing animation.
module flappy_frame_sync
  import flappy_pkg::*;
#(
  parameter int unsigned FLAP_FRAMES = DefFlapFrames
) (
  input  logic       vga_clk,
  input  logic       clrn,
  input  logic       rdn,
  input  logic [8:0] row_addr,
  input  obj_pos_t   pos,
  output logic       frame_end,
  output logic       frame_tick,
  output obj_pos_t   shadow,
  output logic       wing
);

  localparam int unsigned CntW = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;

  logic            rdn_q;
  logic            tick_q, tick_d;
  obj_pos_t        shadow_q, shadow_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wing_q, wing_d;

  // rdn rising out of the last visible row; rdn_q resets high so a reset never fakes an end
  assign frame_end = !rdn_q && rdn && (row_addr == 9'(ScreenH - 1));

  // Next state: everything moves only on the frame-end edge, except the one-cycle tick
  always_comb begin
    tick_d   = frame_end;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    wing_d   = wing_q;
    if (frame_end) begin
      shadow_d = pos;
      if (cnt_q == CntW'(FLAP_FRAMES - 1)) begin
        cnt_d  = '0;
        wing_d = !wing_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      rdn_q    <= 1'b1;
      tick_q   <= 1'b0;
      shadow_q <= ObjPosReset;
      cnt_q    <= '0;
      wing_q   <= 1'b0;
    end else begin
      rdn_q    <= rdn;
      tick_q   <= tick_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      wing_q   <= wing_d;
    end
  end

  assign frame_tick = tick_q;
  assign shadow     = shadow_q;
  assign wing       = wing_q;

endmodule

// File: rtl/flappy_pixel_gen.sv
// Combinational pixel source (sky, ground, two pipes, bird) with per-frame collision flag.
module flappy_pixel_gen
  import flappy_pkg::*;
#(
  parameter int unsigned BIRD_X      = DefBirdX,
  parameter int unsigned BIRD_W      = DefBirdW,
  parameter int unsigned BIRD_H      = DefBirdH,
  parameter int unsigned PIPE_W      = DefPipeW,
  parameter int unsigned GAP_H       = DefGapH,
  parameter int unsigned GROUND_Y    = DefGroundY,
  parameter int unsigned FLAP_FRAMES = DefFlapFrames
) (
  input  logic               vga_clk,
  input  logic               clrn,
  flappy_pixel_gen_if.slave  pix,
  input  logic [8:0]         bird_y,
  input  logic [9:0]         pipe0_x,
  input  logic [9:0]         pipe1_x,
  input  logic [8:0]         pipe0_gap,
  input  logic [8:0]         pipe1_gap,
  output logic               frame_tick,
  output logic               hit
);

  obj_pos_t    pos, sh;
  logic        frame_end, wing;
  logic [10:0] row11, col11;
  logic        is_bird, is_wing, is_pipe, is_ground, overlap;
  logic [11:0] px;
  logic        hit_q, hit_d, hit_acc_q, hit_acc_d;

  assign pos = '{bird_y: bird_y, pipe0_x: pipe0_x, pipe0_gap: pipe0_gap,
                 pipe1_x: pipe1_x, pipe1_gap: pipe1_gap};

  flappy_frame_sync #(
    .FLAP_FRAMES (FLAP_FRAMES)
  ) u_frame_sync (
    .vga_clk    (vga_clk),
    .clrn       (clrn),
    .rdn        (pix.rdn),
    .row_addr   (pix.row_addr),
    .pos        (pos),
    .frame_end  (frame_end),
    .frame_tick (frame_tick),
    .shadow     (sh),
    .wing       (wing)
  );

  // Pipe body outside its gap and above the ground; x >= 640 means parked off-screen
  function automatic logic pipe_at(input logic [10:0] col, input logic [10:0] row,
                                   input logic [9:0] x, input logic [8:0] gap);
    return (x < 10'(ScreenW)) && in_span(col, {1'b0, x}, 11'(PIPE_W)) &&
           !in_span(row, {2'b0, gap}, 11'(GAP_H)) && (row < 11'(GROUND_Y));
  endfunction

  // Object hit-tests and priority colour mux; output forced dark while in reset
  always_comb begin
    row11     = {2'b0, pix.row_addr};
    col11     = {1'b0, pix.col_addr};
    is_bird   = in_span(col11, 11'(BIRD_X), 11'(BIRD_W)) &&
                in_span(row11, {2'b0, sh.bird_y}, 11'(BIRD_H));
    is_wing   = wing && (row11 >= {2'b0, sh.bird_y} + 11'(BIRD_H / 2));
    is_pipe   = pipe_at(col11, row11, sh.pipe0_x, sh.pipe0_gap) ||
                pipe_at(col11, row11, sh.pipe1_x, sh.pipe1_gap);
    is_ground = row11 >= 11'(GROUND_Y);
    overlap   = !pix.rdn && is_bird && (is_pipe || is_ground);

    px = ColSky;
    if (!clrn || pix.rdn) begin
      px = ColBlank;
    end else if (is_bird) begin
      px = is_wing ? ColWing : ColBird;
    end else if (is_pipe) begin
      px = ColPipe;
    end else if (is_ground) begin
      px = ColGround;
    end
  end

  assign pix.d_in = px;

  // Collision accumulates over the frame and is published at frame end
  always_comb begin
    hit_acc_d = hit_acc_q | overlap;
    hit_d     = hit_q;
    if (frame_end) begin
      hit_d     = hit_acc_q | overlap;
      hit_acc_d = 1'b0;
    end
  end

  // Collision registers
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      hit_q     <= 1'b0;
      hit_acc_q <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      hit_acc_q <= hit_acc_d;
    end
  end

  assign hit = hit_q;

endmodule
